// File: rtl/uart_pkg.sv
// Shared types for the UART stimulus transmitter.
//   parity_e   : parity mode selected at elaboration (none / odd / even)
//   tx_state_e : transmit FSM states, IDLE through STOP
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_ODD,
      PAR_EVEN
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_e;

   // Bit counter width: enough for up to 8 data bits or 2 stop bits.
   localparam int unsigned BIT_CNT_W = 3;

endpackage : uart_pkg

// File: rtl/stream_fifo.sv
// Synchronous FIFO buffering bytes in front of the UART transmitter.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (flushes contents)
//   push, push_data   : write request and data; ignored while full
//   pop, pop_data     : read request; pop_data always shows the head entry
//   full, empty       : occupancy flags
//   level             : number of stored entries, 0..DEPTH
module stream_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  logic [WIDTH-1:0]                 push_data,
   input  logic                             pop,
   output logic [WIDTH-1:0]                 pop_data,
   output logic                             full,
   output logic                             empty,
   output logic [$clog2(DEPTH+1)-1:0]       level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("stream_fifo: DEPTH must be a power of 2 and at least 2");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_q == LVL_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign level    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;

   // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH on their own.
   // NOTE: every variable gets a default at the top of always_comb so no path can
   // leave it unassigned; an unassigned path would infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // A simultaneous push and pop leaves the count where it is.
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + LVL_W'(1);
         2'b01:   count_d = count_q - LVL_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; clearing the pointers
   // and count is enough to make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule : stream_fifo

// File: rtl/uart_tx_stim.sv
// Buffered UART transmitter used as a stimulus source for the SoC UART receiver.
// Bytes are queued in a stream_fifo and sent as start bit, LSB-first data,
// optional parity bit and one or two stop bits, each CLK_DIV clocks long.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset (aborts frame, flushes FIFO)
//   in_valid, in_data  : byte offer; accepted on an edge where in_ready is 1
//   in_ready           : FIFO has room
//   tx                 : serial output, idle high
//   busy               : a frame is in progress (FSM not in IDLE)
//   level              : bytes currently buffered
//   byte_done          : one-cycle pulse in the last cycle of the last stop bit
module uart_tx_stim
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned DATA_BITS  = 8,
   parameter parity_e     PARITY     = PAR_NONE,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   input  logic [DATA_BITS-1:0]                in_data,
   output logic                                in_ready,
   output logic                                tx,
   output logic                                busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     level,
   output logic                                byte_done
);

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("uart_tx_stim: CLK_DIV must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_stim: DATA_BITS must be in 5..8");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
      $error("uart_tx_stim: PARITY must be PAR_NONE, PAR_ODD or PAR_EVEN");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_stim: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("uart_tx_stim: FIFO_DEPTH must be a power of 2 and at least 2");
   end

   localparam int unsigned          BAUD_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BAUD_W-1:0]    BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_DATA   = BIT_CNT_W'(DATA_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_STOP   = BIT_CNT_W'(STOP_BITS - 1);
   localparam logic                 ODD_FLIP    = (PARITY == PAR_ODD);

   tx_state_e              state_q, state_d;
   logic [BAUD_W-1:0]      baud_q, baud_d;
   logic [BIT_CNT_W-1:0]   bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;

   logic                   bit_end;
   logic                   load_frame;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [DATA_BITS-1:0]   fifo_rd_data;

   assign in_ready  = ~fifo_full;
   assign fifo_push = in_valid & ~fifo_full;
   assign busy      = (state_q != IDLE);
   // The baud counter counts down; reaching zero marks the last cycle of a bit.
   assign bit_end   = (baud_q == '0);

   stream_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (in_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_d      = par_q;
      load_frame = 1'b0;
      fifo_pop   = 1'b0;
      byte_done  = 1'b0;

      // Inside a frame the baud counter reloads on every bit boundary.
      if (state_q != IDLE) begin
         baud_d = bit_end ? BAUD_RELOAD : baud_q - BAUD_W'(1);
      end

      case (state_q)
         IDLE: begin
            load_frame = ~fifo_empty;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
                  state_d = (PARITY == PAR_NONE) ? STOP : PAR;
               end else begin
                  bit_d = bit_q + BIT_CNT_W'(1);
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               state_d = STOP;
               bit_d   = '0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_q == LAST_STOP) begin
                  byte_done = 1'b1;
                  // Chain straight into the next frame when a byte is waiting.
                  if (!fifo_empty) begin
                     load_frame = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_d = bit_q + BIT_CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Pop the head and start a frame on the same edge. Parity is computed
      // here, before the shift register starts consuming the data bits.
      if (load_frame) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_rd_data;
         par_d    = (^fifo_rd_data) ^ ODD_FLIP;
         state_d  = START;
         baud_d   = BAUD_RELOAD;
         bit_d    = '0;
      end
   end

   // tx decodes directly from registered state, so reset forces it high at once.
   always_comb begin
      tx = 1'b1;
      case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = shift_q[0];
         PAR:     tx = par_q;
         default: tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
      end
   end

endmodule : uart_tx_stim

// File: tb/tb_uart_tx_stim.sv
// Self-checking bench for uart_tx_stim. Five instances cover 8N1, 8E1, 8O1,
// 8N2 and 7N1 configurations; a receiver model decodes every frame cycle by cycle.
module tb_uart_tx_stim;
   import uart_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       in_valid_w [5];
   logic [7:0] in_data_w  [4];
   logic [6:0] in_data_7;
   logic       in_ready_w [5];
   logic       tx_w       [5];
   logic       busy_w     [5];
   logic [2:0] level_w    [5];
   logic       done_w     [5];

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int         idx;
      int         div;
      int         nbits;
      int         par;     // 0 none, 1 odd, 2 even
      int         nstop;
      logic [7:0] data;
      logic       exp_par;
      int         exp_len;
   } frame_vec_t;

   frame_vec_t vecs [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   uart_tx_stim #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w[0]), .in_data(in_data_w[0]), .in_ready(in_ready_w[0]),
      .tx(tx_w[0]), .busy(busy_w[0]), .level(level_w[0]), .byte_done(done_w[0]));
   uart_tx_stim #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w[1]), .in_data(in_data_w[1]), .in_ready(in_ready_w[1]),
      .tx(tx_w[1]), .busy(busy_w[1]), .level(level_w[1]), .byte_done(done_w[1]));
   uart_tx_stim #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w[2]), .in_data(in_data_w[2]), .in_ready(in_ready_w[2]),
      .tx(tx_w[2]), .busy(busy_w[2]), .level(level_w[2]), .byte_done(done_w[2]));
   uart_tx_stim #(.CLK_DIV(2), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8n2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w[3]), .in_data(in_data_w[3]), .in_ready(in_ready_w[3]),
      .tx(tx_w[3]), .busy(busy_w[3]), .level(level_w[3]), .byte_done(done_w[3]));
   uart_tx_stim #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7n1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w[4]), .in_data(in_data_7), .in_ready(in_ready_w[4]),
      .tx(tx_w[4]), .busy(busy_w[4]), .level(level_w[4]), .byte_done(done_w[4]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_data(input int idx, input logic [7:0] d);
      if (idx == 4) in_data_7 = d[6:0];
      else          in_data_w[idx] = d;
   endtask

   // Starts at a negedge, holds the offer across one rising edge.
   task automatic push_one(input int idx, input logic [7:0] d);
      in_valid_w[idx] = 1'b1;
      set_data(idx, d);
      @(posedge clk);
      @(negedge clk);
      in_valid_w[idx] = 1'b0;
   endtask

   // Receiver model: waits for the start bit, then samples every cycle of the
   // frame on falling edges. Returns at the negedge of the frame's last cycle.
   task automatic rx_frame(input int idx, input int div, input int nbits, input int par,
                           input int nstop, input logic [7:0] data, input logic exp_par,
                           input int exp_len, input int exp_wait, input string tag);
      logic [11:0] exp_bits;
      logic [11:0] smp;
      logic [7:0]  decoded;
      int nb, pos, waited, bad_tx, bad_done, bad_busy, done_at, stop_bad;
      exp_bits = '1;
      smp      = '0;
      nb = 1 + nbits + ((par != 0) ? 1 : 0) + nstop;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < nbits; i++) exp_bits[1+i] = data[i];
      pos = 1 + nbits;
      if (par != 0) exp_bits[pos] = exp_par;

      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (tx_w[idx] !== 1'b0 && waited < 200);
      check({tag, " start latency"}, waited, exp_wait);
      if (tx_w[idx] !== 1'b0) return;

      bad_tx = 0; bad_done = 0; bad_busy = 0; done_at = -1;
      for (int p = 0; p < nb; p++) begin
         for (int c = 0; c < div; c++) begin
            if (p != 0 || c != 0) @(negedge clk);
            if (tx_w[idx] !== exp_bits[p]) bad_tx++;
            if (busy_w[idx] !== 1'b1) bad_busy++;
            if (done_w[idx] !== ((p == nb - 1) && (c == div - 1))) bad_done++;
            if (done_w[idx] === 1'b1 && done_at < 0) done_at = p * div + c;
            if (c == div / 2) smp[p] = tx_w[idx];
         end
      end

      decoded = '0;
      for (int i = 0; i < nbits; i++) decoded[i] = smp[1+i];
      check({tag, " decoded byte"}, decoded, data);
      if (par != 0) check({tag, " parity bit"}, smp[1+nbits], exp_par);
      stop_bad = 0;
      for (int i = 0; i < nstop; i++) if (smp[nb-1-i] !== 1'b1) stop_bad++;
      check({tag, " stop bits"}, stop_bad, 0);
      check({tag, " tx cycle errors"}, bad_tx, 0);
      check({tag, " busy low in frame"}, bad_busy, 0);
      check({tag, " byte_done misplaced"}, bad_done, 0);
      check({tag, " frame length"}, done_at + 1, exp_len);
   endtask

   initial begin
      int bad;
      //          idx div nb par ns data   par len
      vecs[0] = '{0, 4, 8, 0, 1, 8'h55, 1'b0, 40};
      vecs[1] = '{1, 4, 8, 2, 1, 8'h07, 1'b1, 44};
      vecs[2] = '{2, 4, 8, 1, 1, 8'h07, 1'b0, 44};
      vecs[3] = '{1, 4, 8, 2, 1, 8'h80, 1'b1, 44};
      vecs[4] = '{2, 4, 8, 1, 1, 8'h00, 1'b1, 44};
      vecs[5] = '{1, 4, 8, 2, 1, 8'hFF, 1'b0, 44};
      vecs[6] = '{3, 2, 8, 0, 2, 8'h5A, 1'b0, 22};
      vecs[7] = '{4, 4, 7, 0, 1, 8'h7F, 1'b0, 36};

      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) in_valid_w[i] = 1'b0;
      for (int i = 0; i < 4; i++) in_data_w[i] = '0;
      in_data_7 = '0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         check($sformatf("reset tx[%0d]", i), tx_w[i], 1);
         check($sformatf("reset busy[%0d]", i), busy_w[i], 0);
         check($sformatf("reset in_ready[%0d]", i), in_ready_w[i], 1);
         check($sformatf("reset level[%0d]", i), level_w[i], 0);
         check($sformatf("reset byte_done[%0d]", i), done_w[i], 0);
      end

      // Release at a negedge; vector 0 is offered for the very next rising edge.
      rst_n = 1'b1;
      for (int v = 0; v < 8; v++) begin
         fork
            push_one(vecs[v].idx, vecs[v].data);
            rx_frame(vecs[v].idx, vecs[v].div, vecs[v].nbits, vecs[v].par, vecs[v].nstop,
                     vecs[v].data, vecs[v].exp_par, vecs[v].exp_len, 2, $sformatf("vec%0d", v));
         join
         @(negedge clk);
         check($sformatf("vec%0d idle busy", v), busy_w[vecs[v].idx], 0);
         check($sformatf("vec%0d idle tx", v), tx_w[vecs[v].idx], 1);
      end

      // 8N2 burst: three consecutive pushes give three back-to-back frames.
      fork
         begin
            in_valid_w[3] = 1'b1;
            in_data_w[3] = 8'hA3; @(posedge clk); @(negedge clk);
            in_data_w[3] = 8'h00; @(posedge clk); @(negedge clk);
            in_data_w[3] = 8'hFF; @(posedge clk); @(negedge clk);
            in_valid_w[3] = 1'b0;
         end
         begin
            rx_frame(3, 2, 8, 0, 2, 8'hA3, 1'b0, 22, 2, "burst0");
            rx_frame(3, 2, 8, 0, 2, 8'h00, 1'b0, 22, 1, "burst1");
            rx_frame(3, 2, 8, 0, 2, 8'hFF, 1'b0, 22, 1, "burst2");
         end
      join
      @(negedge clk);
      check("burst idle busy", busy_w[3], 0);

      // Overflow: with a frame running, five pushes into a 4-deep FIFO.
      fork
         begin
            push_one(0, 8'h11);
            repeat (3) @(negedge clk);
            for (int k = 0; k < 5; k++) begin
               in_valid_w[0] = 1'b1;
               in_data_w[0] = 8'(8'h21 + k);
               if (k == 4) begin
                  check("ovf level full", level_w[0], 4);
                  check("ovf in_ready full", in_ready_w[0], 0);
               end
               @(posedge clk);
               @(negedge clk);
            end
            in_valid_w[0] = 1'b0;
            check("ovf level after drop", level_w[0], 4);
         end
         begin
            rx_frame(0, 4, 8, 0, 1, 8'h11, 1'b0, 40, 2, "ovf f0");
            for (int k = 0; k < 4; k++)
               rx_frame(0, 4, 8, 0, 1, 8'(8'h21 + k), 1'b0, 40, 1, $sformatf("ovf f%0d", k + 1));
         end
      join
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
      end
      check("ovf dropped byte not sent", bad, 0);
      check("ovf level drained", level_w[0], 0);

      // 7N1 reset in data bit 3 of 0x35 (bit 3 is 0), with one byte queued.
      push_one(4, 8'h35);
      bad = 0;
      while (tx_w[4] !== 1'b0 && bad < 50) begin
         @(negedge clk);
         bad++;
      end
      check("rst start latency", bad, 1);
      push_one(4, 8'h66);
      repeat (16) @(negedge clk);
      check("rst pre level", level_w[4], 1);
      check("rst pre busy", busy_w[4], 1);
      check("rst pre tx data bit 3", tx_w[4], 0);
      #2 rst_n = 1'b0;
      #1;
      check("rst async tx", tx_w[4], 1);
      check("rst async level", level_w[4], 0);
      check("rst async busy", busy_w[4], 0);
      check("rst async in_ready", in_ready_w[4], 1);
      check("rst async byte_done", done_w[4], 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (tx_w[4] !== 1'b1 || busy_w[4] !== 1'b0) bad++;
      end
      check("rst no resumed frame", bad, 0);
      fork
         push_one(4, 8'h41);
         rx_frame(4, 4, 7, 0, 1, 8'h41, 1'b0, 36, 2, "rst 0x41");
      join
      @(negedge clk);
      check("rst final busy", busy_w[4], 0);
      check("rst final level", level_w[4], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_uart_tx_stim

// File: doc/uart_tx_stim.md
UART_TX_STIM -- requirements
Module: uart_tx_stim

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4: clk cycles per UART bit, legal range 2 or more.
REQ-002 The module SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-003 The module SHALL have parameter PARITY, default PAR_NONE: parity mode, one of PAR_NONE, PAR_ODD or PAR_EVEN.
REQ-004 The module SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 8: transmit buffer entries, a power of 2 and at least 2.
REQ-006 Illegal parameter values SHALL cause an elaboration-time error.
REQ-007 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The module SHALL have port in_valid, input, 1 bit: a byte is offered on in_data.
REQ-010 The module SHALL have port in_data, input, DATA_BITS wide: the byte to transmit.
REQ-011 The module SHALL have port in_ready, output, 1 bit: the buffer can accept a byte.
REQ-012 The module SHALL have port tx, output, 1 bit: UART serial line, idle high, intended to drive the SoC isp_uart_rx.
REQ-013 The module SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-014 The module SHALL have port level, output, $clog2(FIFO_DEPTH+1) wide: number of bytes currently buffered.
REQ-015 The module SHALL have port byte_done, output, 1 bit: a one-cycle pulse when a frame completes.

Function
REQ-016 A byte SHALL be pushed on a rising edge where in_valid and in_ready are both 1; in_ready SHALL equal (level != FIFO_DEPTH).
REQ-017 When the FIFO is full, in_valid SHALL be ignored, with no overwrite and no error state.
REQ-018 The FSM states SHALL be IDLE, START, DATA, PAR and STOP; PAR SHALL be skipped when PARITY is PAR_NONE.
REQ-019 In IDLE with level>0, the FSM SHALL pop the FIFO head and enter START on the same edge, so tx goes low 1 cycle after the byte is available.
REQ-020 Each bit SHALL hold tx for exactly CLK_DIV cycles, timed by a baud counter that reloads on every bit boundary.
REQ-021 The start bit SHALL be 0, data SHALL be sent LSB first, and stop bits SHALL be 1.
REQ-022 The parity bit SHALL be the XOR of the DATA_BITS data bits, inverted when PARITY is PAR_ODD.
REQ-023 Frame length SHALL be CLK_DIV*(1+DATA_BITS+P+STOP_BITS) cycles, where P=1 with parity and 0 without.
REQ-024 byte_done SHALL be 1 for exactly the last cycle of the last stop bit.
REQ-025 At the end of the last stop bit with level>0, the FSM SHALL pop and enter START directly, giving back-to-back frames with no idle cycle.
REQ-026 A simultaneous push and pop SHALL leave level unchanged and lose no data.
REQ-027 A push into an empty FIFO while in IDLE SHALL start a frame on the next edge.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 While rst_n=0, outputs SHALL be tx=1, busy=0, in_ready=1, level=0 and byte_done=0, applied asynchronously.
REQ-031 Reset mid-frame SHALL abort the frame, force tx=1 immediately and flush the FIFO; no partial frame SHALL resume after release.
REQ-032 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package uart_pkg SHALL hold the parity enum (PAR_NONE, PAR_ODD, PAR_EVEN) and the FSM state typedef.
REQ-034 The buffer SHALL be a separate sub-module, stream_fifo, parametrised by WIDTH and DEPTH and exposing push, pop, full, empty and level.
REQ-035 The baud counter, bit counter, shift register and FSM SHALL reside in uart_tx_stim.

Verification
REQ-036 Scenario 8N1, CLK_DIV=4: push 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; busy for 40 cycles; byte_done at cycle 40.
REQ-037 Scenario 8E1, CLK_DIV=4: push 0x07 -> parity bit 1; frame 44 cycles. Scenario 8O1 with the same byte -> parity bit 0.
REQ-038 Scenario 8N2, CLK_DIV=2: push 0xA3, 0x00, 0xFF in consecutive cycles -> busy high for a continuous 66 cycles; 3 byte_done pulses 22 cycles apart.
REQ-039 Scenario FIFO_DEPTH=4, a frame in progress: push 5 bytes -> level reaches 4, in_ready=0, 5th byte dropped; all 4 accepted bytes are sent in order.
REQ-040 Scenario 7N1: rst_n low during data bit 3 -> tx=1 and level=0 at once; after release, push 0x41 -> one clean frame.
REQ-041 Every bench SHALL include a receiver model that checks each decoded byte and stop bit against the pushed data.
